// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: queues bytes in a FIFO and, on a start request,
// drains the whole queue onto the serial line, returning one done pulse per burst.
module uart_tx_buffered #(
  parameter int NB_DATA         = 8,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int OVERSAMPLE      = 16,
  parameter int SB_TICK         = 16
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_wr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic               i_tx_start,
  output logic               o_tx,
  output logic               o_tx_done,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_overflow,
  output logic               o_busy
);

  localparam int DEPTH  = 2 ** FIFO_ADDR_WIDTH;
  localparam int CNT_W  = FIFO_ADDR_WIDTH + 1;
  localparam int TICK_W = $clog2((OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK);
  localparam int BIT_W  = $clog2(NB_DATA);

  localparam logic [TICK_W-1:0] OS_LAST   = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NB_DATA - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [NB_DATA-1:0]         mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]           count;
  logic [CNT_W-1:0]           count_next;
  logic                       full;
  logic                       empty;
  logic                       overflow;
  logic                       push;
  logic                       pop;

  // Transmit FSM
  state_t             state, state_next;
  logic [TICK_W-1:0]  tick_cnt, tick_cnt_next;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_next;
  logic [NB_DATA-1:0] shift, shift_next;
  logic               tx, tx_next;
  logic               done, done_next;
  logic               go;
  logic               go_clr;

  // A pop frees a slot in the same cycle, so a write at full is legal then.
  assign push = i_wr && (!full || pop);

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(1);
      end
      count <= count_next;
      full  <= (count_next == CNT_FULL);
      empty <= (count_next == '0);
      if (i_wr && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Go flag: a start while busy is ignored; cleared together with the done pulse.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      go <= 1'b0;
    end else if (go_clr) begin
      go <= 1'b0;
    end else if (i_tx_start) begin
      go <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_cnt_next;
      bit_cnt  <= bit_cnt_next;
      shift    <= shift_next;
      tx       <= tx_next;
      done     <= done_next;
    end
  end

  always_comb begin
    state_next    = state;
    tick_cnt_next = tick_cnt;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift;
    pop           = 1'b0;
    done_next     = 1'b0;
    go_clr        = 1'b0;

    case (state)
      IDLE: begin
        if (go) begin
          if (!empty) begin
            shift_next    = mem[rd_ptr];
            pop           = 1'b1;
            tick_cnt_next = '0;
            state_next    = START;
          end else begin
            done_next = 1'b1;
            go_clr    = 1'b1;
          end
        end
      end

      START: begin
        if (i_tick) begin
          if (tick_cnt == OS_LAST) begin
            tick_cnt_next = '0;
            bit_cnt_next  = '0;
            state_next    = DATA;
          end else begin
            tick_cnt_next = tick_cnt + TICK_W'(1);
          end
        end
      end

      DATA: begin
        if (i_tick) begin
          if (tick_cnt == OS_LAST) begin
            tick_cnt_next = '0;
            shift_next    = shift >> 1;
            if (bit_cnt == BIT_LAST) begin
              state_next = STOP;
            end else begin
              bit_cnt_next = bit_cnt + BIT_W'(1);
            end
          end else begin
            tick_cnt_next = tick_cnt + TICK_W'(1);
          end
        end
      end

      STOP: begin
        if (i_tick) begin
          if (tick_cnt == STOP_LAST) begin
            tick_cnt_next = '0;
            state_next    = IDLE;
          end else begin
            tick_cnt_next = tick_cnt + TICK_W'(1);
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Line level follows the next state so o_tx comes straight from a flop.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign o_tx       = tx;
  assign o_tx_done  = done;
  assign o_full     = full;
  assign o_empty    = empty;
  assign o_overflow = overflow;
  assign o_busy     = go;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a line monitor decodes every 8N1 frame tick by tick
// and compares it against a queue of bytes expected in transmit order.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_tick;
  logic       i_wr;
  logic [7:0] i_wdata;
  logic       i_tx_start;
  logic       o_tx;
  logic       o_tx_done;
  logic       o_full;
  logic       o_empty;
  logic       o_overflow;
  logic       o_busy;

  always #5 clk = ~clk;

  uart_tx_buffered dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_tick     (i_tick),
    .i_wr       (i_wr),
    .i_wdata    (i_wdata),
    .i_tx_start (i_tx_start),
    .o_tx       (o_tx),
    .o_tx_done  (o_tx_done),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_overflow (o_overflow),
    .o_busy     (o_busy)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // tick every 4th clock
  initial begin
    int t;
    t = 0;
    i_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      t++;
      i_tick = (t % 4 == 0);
    end
  end

  // line monitor
  bit         inframe = 0;
  int         k = 0;
  logic [9:0] bits;
  bit         unstable;
  int         since_end = 0;
  bit         pend_done = 0;
  bit         after_frame = 0;
  bit         contig = 0;
  int         done_cnt = 0;

  always @(negedge clk) begin
    logic [7:0] exp_b;
    int slot;
    if (i_rst) begin
      inframe     = 0;
      pend_done   = 0;
      after_frame = 0;
    end else begin
      since_end++;
      if (o_tx_done) begin
        done_cnt++;
        if (pend_done) check("done_latency", since_end, 2);
        pend_done   = 0;
        after_frame = 0;
      end
      if (!inframe && o_tx === 1'b0) begin
        inframe   = 1;
        k         = 0;
        unstable  = 0;
        pend_done = 0;
        if (contig && after_frame) check("frame_gap", since_end, 2);
      end
      if (inframe && i_tick) begin
        slot = k / 16;
        if (k % 16 == 0) bits[slot] = o_tx;
        else if (o_tx !== bits[slot]) unstable = 1;
        k++;
        if (k == 160) begin
          inframe = 0;
          check("start_bit", bits[0], 0);
          check("stop_bit", bits[9], 1);
          check("bit_width", unstable, 0);
          if (sb.size() == 0) begin
            check("unexpected_frame", bits[8:1], 32'hFFFF_FFFF);
          end else begin
            exp_b = sb.pop_front();
            check("frame_data", bits[8:1], exp_b);
          end
          since_end   = 0;
          pend_done   = 1;
          after_frame = 1;
        end
      end
    end
  end

  task automatic wr(input logic [7:0] d);
    i_wr    = 1'b1;
    i_wdata = d;
    @(posedge clk);
    #1;
    i_wr = 1'b0;
  endtask

  task automatic start_pulse();
    i_tx_start = 1'b1;
    @(posedge clk);
    #1;
    i_tx_start = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    sb.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    check({tag, "_tx"}, o_tx, 1);
    check({tag, "_done"}, o_tx_done, 0);
    check({tag, "_full"}, o_full, 0);
    check({tag, "_empty"}, o_empty, 1);
    check({tag, "_overflow"}, o_overflow, 0);
    check({tag, "_busy"}, o_busy, 0);
  endtask

  // wait for the burst's done pulse, then confirm exactly one and a drained queue
  task automatic finish_burst(input string tag, input int d0, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_tx_done && n < budget);
    check({tag, "_done_seen"}, o_tx_done, 1);
    repeat (40) @(negedge clk);
    check({tag, "_done_count"}, done_cnt - d0, 1);
    check({tag, "_frames_left"}, sb.size(), 0);
    check({tag, "_empty"}, o_empty, 1);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_tx_idle"}, o_tx, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    bit txlow;
    logic [7:0] b;

    i_rst = 1'b1;
    i_wr = 1'b0;
    i_wdata = '0;
    i_tx_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    check_idle_outputs("reset");

    // single byte
    @(posedge clk); #1;
    wr(8'hA5);
    sb.push_back(8'hA5);
    d0 = done_cnt;
    start_pulse();
    finish_burst("single", d0, 2000);

    // burst with a byte appended mid-burst, plus an ignored start while busy
    contig = 1;
    wr(8'h00);
    wr(8'hFF);
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    d0 = done_cnt;
    start_pulse();
    repeat (100) @(posedge clk);
    #1;
    wr(8'h3C);
    sb.push_back(8'h3C);
    start_pulse();
    @(negedge clk);
    check("burst_busy", o_busy, 1);
    @(posedge clk); #1;
    finish_burst("burst", d0, 5000);
    contig = 0;

    // empty start
    @(posedge clk); #1;
    d0 = done_cnt;
    i_tx_start = 1'b1;
    @(posedge clk);
    #1;
    i_tx_start = 1'b0;
    n = 0;
    txlow = 0;
    do begin
      @(negedge clk);
      n++;
      if (o_tx !== 1'b1) txlow = 1;
    end while (!o_tx_done && n < 10);
    check("empty_start_latency", n, 2);
    repeat (10) @(negedge clk);
    check("empty_start_tx_high", txlow, 0);
    check("empty_start_busy", o_busy, 0);
    check("empty_start_done_count", done_cnt - d0, 1);

    // fill, overflow, drain
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      b = 8'(i * 37 + 11);
      wr(b);
      sb.push_back(b);
    end
    @(negedge clk);
    check("fill_full", o_full, 1);
    check("fill_overflow", o_overflow, 0);
    @(posedge clk); #1;
    wr(8'h77);
    @(negedge clk);
    check("ovf_flag", o_overflow, 1);
    check("ovf_full", o_full, 1);
    check("ovf_empty", o_empty, 0);
    @(posedge clk); #1;
    d0 = done_cnt;
    contig = 1;
    start_pulse();
    finish_burst("drain16", d0, 12000);
    contig = 0;
    check("ovf_sticky", o_overflow, 1);

    do_reset();
    check_idle_outputs("reset2");

    // write coinciding with the pop at full
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      b = 8'(8'hE0 ^ i);
      wr(b);
      sb.push_back(b);
    end
    d0 = done_cnt;
    contig = 1;
    i_tx_start = 1'b1;
    @(posedge clk);
    #1;
    i_tx_start = 1'b0;
    i_wr = 1'b1;
    i_wdata = 8'h99;
    @(posedge clk);
    #1;
    i_wr = 1'b0;
    sb.push_back(8'h99);
    @(negedge clk);
    check("simul_overflow", o_overflow, 0);
    check("simul_full", o_full, 1);
    @(posedge clk); #1;
    finish_burst("simul", d0, 13000);
    contig = 0;

    // reset in the middle of a frame
    wr(8'h5A);
    wr(8'hC3);
    sb.push_back(8'h5A);
    sb.push_back(8'hC3);
    start_pulse();
    repeat (200) @(posedge clk);
    #1;
    do_reset();
    check_idle_outputs("midreset");
    txlow = 0;
    repeat (800) begin
      @(negedge clk);
      if (o_tx !== 1'b1) txlow = 1;
    end
    check("midreset_quiet", txlow, 0);
    check("midreset_done_none", o_tx_done, 0);
    @(posedge clk); #1;
    wr(8'h81);
    sb.push_back(8'h81);
    d0 = done_cnt;
    start_pulse();
    finish_burst("after_reset", d0, 2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
